// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N-channel push-button debouncer with press/release pulses
// Optional auto-repeat pulses are built only when DEBOUNCE_REPEAT_EN is defined.
module btn_debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int ACTIVE_HIGH   = 1,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic            clk_100MHz,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (N_CH < 1 || STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("btn_debounce_multi: N_CH, STABLE_CYCLES and repeat timings must all be >= 1");
    end

    logic [N_CH-1:0]  pin_norm;
    logic [N_CH-1:0]  sync_q1;
    logic [N_CH-1:0]  sync_q2;
    state_t           state [N_CH];
    logic [CNT_W-1:0] cnt   [N_CH];

    // Polarity is normalised before the synchroniser so its reset value is always "not pressed".
    assign pin_norm = (ACTIVE_HIGH != 0) ? btn_in : ~btn_in;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= pin_norm;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_CH; i++) begin
                case (state[i])
                    IDLE: begin
                        if (sync_q2[i]) begin
                            state[i] <= PRESS_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync_q2[i]) begin
                            state[i] <= IDLE;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i]     <= PRESSED;
                            btn_level[i] <= 1'b1;
                            btn_press[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!sync_q2[i]) begin
                            state[i] <= RELEASE_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync_q2[i]) begin
                            state[i] <= PRESSED;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i]       <= IDLE;
                            btn_level[i]   <= 1'b0;
                            btn_release[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_WRAP  = HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_cnt [N_CH];
    logic [HOLD_W-1:0] hold_nxt [N_CH];
    logic [N_CH-1:0]   rel_accept;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            hold_nxt[i]   = hold_cnt[i] + HOLD_W'(1);
            rel_accept[i] = (state[i] == RELEASE_WAIT) && !sync_q2[i] && (cnt[i] == CNT_MAX);
        end
    end

    // hold_cnt counts cycles since the press pulse; after the first repeat it loops
    // between HOLD_FIRST and HOLD_WRAP so it never needs more than HOLD_W bits.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                hold_cnt[i] <= '0;
            end
            btn_repeat <= '0;
        end else begin
            btn_repeat <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (!btn_level[i] || rel_accept[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_nxt[i] == HOLD_WRAP) begin
                    hold_cnt[i]   <= HOLD_FIRST;
                    btn_repeat[i] <= 1'b1;
                end else begin
                    hold_cnt[i]   <= hold_nxt[i];
                    btn_repeat[i] <= (hold_nxt[i] == HOLD_FIRST);
                end
            end
        end
    end
`else
    assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - self-checking bench for btn_debounce_multi
module tb_btn_debounce_multi;

    localparam int N  = 4;
    localparam int SC = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic         clk_100MHz = 1'b0;
    logic         rst_n      = 1'b0;
    logic [N-1:0] btn_in     = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;

    always #5 clk_100MHz = ~clk_100MHz;

    btn_debounce_multi #(
        .N_CH(N), .STABLE_CYCLES(SC), .ACTIVE_HIGH(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    // Model: a pin value seen two edges late becomes the level once it has been
    // sampled unchanged for SC+1 consecutive edges while differing from the level.
    logic [N-1:0] m_p1 = '0, m_p2 = '0, m_s = '0, m_val = '0;
    logic [N-1:0] m_lvl = '0, m_press = '0, m_rel = '0, m_rep = '0;
    int m_run [N];
    int m_hc  [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_hc[i]  = 0;
        end
        forever begin
            @(posedge clk_100MHz or negedge rst_n);
            if (!rst_n) begin
                m_p1 = '0; m_p2 = '0; m_val = '0; m_lvl = '0;
                m_press = '0; m_rel = '0; m_rep = '0;
                for (int i = 0; i < N; i++) begin
                    m_run[i] = 0;
                    m_hc[i]  = 0;
                end
            end else begin
                m_s  = m_p2;
                m_p2 = m_p1;
                m_p1 = btn_in;
                for (int i = 0; i < N; i++) begin
                    if (m_s[i] == m_val[i]) begin
                        if (m_run[i] <= SC) m_run[i]++;
                    end else begin
                        m_val[i] = m_s[i];
                        m_run[i] = 1;
                    end
                    m_press[i] = 1'b0;
                    m_rel[i]   = 1'b0;
                    m_rep[i]   = 1'b0;
                    if (m_s[i] != m_lvl[i] && m_run[i] > SC) begin
                        m_lvl[i]   = m_s[i];
                        m_press[i] = m_s[i];
                        m_rel[i]   = ~m_s[i];
                        m_hc[i]    = 0;
                    end else if (m_lvl[i]) begin
                        m_hc[i]++;
`ifdef DEBOUNCE_REPEAT_EN
                        m_rep[i] = (m_hc[i] >= RD) && ((m_hc[i] - RD) % RP == 0);
`endif
                    end
                end
            end
        end
    end

    int cnt_press [N];
    int cnt_rel   [N];
    int cnt_rep   [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            cnt_press[i] = 0;
            cnt_rel[i]   = 0;
            cnt_rep[i]   = 0;
        end
        forever begin
            @(posedge clk_100MHz);
            #2;
            chk("model_level",   btn_level,   m_lvl);
            chk("model_press",   btn_press,   m_press);
            chk("model_release", btn_release, m_rel);
            chk("model_repeat",  btn_repeat,  m_rep);
            for (int i = 0; i < N; i++) begin
                if (btn_press[i] === 1'b1)   cnt_press[i]++;
                if (btn_release[i] === 1'b1) cnt_rel[i]++;
                if (btn_repeat[i] === 1'b1)  cnt_rep[i]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int saved;

    initial begin
        // Reset with all pins held active
        btn_in = 4'hF;
        wait_neg(3);
        chk("rst_level",   btn_level,   4'h0);
        chk("rst_press",   btn_press,   4'h0);
        chk("rst_release", btn_release, 4'h0);
        chk("rst_repeat",  btn_repeat,  4'h0);
        rst_n = 1'b1;
        wait_neg(10);
        chk("rst_press_early", btn_press, 4'h0);
        wait_neg(1);
        chk("rst_press_k10", btn_press, 4'hF);
        chk("rst_level_k10", btn_level, 4'hF);
        wait_neg(1);
        chk("rst_press_width", btn_press, 4'h0);
        btn_in = 4'h0;
        wait_neg(20);
        chk("all_released", btn_level, 4'h0);

        // Bounce on ch0
        saved = cnt_press[0];
        for (int t = 0; t < 40; t++) begin
            btn_in[0] = ((t / 3) % 2 == 0);
            wait_neg(1);
        end
        chk("bounce_no_press", 4'(cnt_press[0] - saved), 4'd0);
        btn_in[0] = 1'b1;
        wait_neg(10);
        chk("bounce_press_early", btn_press, 4'h0);
        wait_neg(1);
        chk("bounce_press_k10", btn_press, 4'h1);
        wait_neg(5);
        chk("bounce_one_press", 4'(cnt_press[0] - saved), 4'd1);

        // Release glitch on ch1
        btn_in[1] = 1'b1;
        wait_neg(15);
        saved = cnt_rel[1];
        btn_in[1] = 1'b0;
        wait_neg(4);
        btn_in[1] = 1'b1;
        wait_neg(15);
        chk("glitch_level", btn_level, 4'h3);
        chk("glitch_no_release", 4'(cnt_rel[1] - saved), 4'd0);
        btn_in[1] = 1'b0;
        wait_neg(10);
        chk("rel_early", btn_release, 4'h0);
        wait_neg(1);
        chk("rel_k10", btn_release, 4'h2);
        chk("rel_level", btn_level, 4'h1);
        wait_neg(1);
        chk("rel_width", btn_release, 4'h0);

        // Independence: ch2 press and ch3 release together
        btn_in[3] = 1'b1;
        wait_neg(15);
        btn_in[2] = 1'b1;
        btn_in[3] = 1'b0;
        wait_neg(10);
        chk("indep_press_early", btn_press, 4'h0);
        wait_neg(1);
        chk("indep_press",   btn_press,   4'h4);
        chk("indep_release", btn_release, 4'h8);
        chk("indep_level",   btn_level,   4'h5);
        btn_in = 4'h0;
        wait_neg(15);
        chk("indep_idle", btn_level, 4'h0);

        // Reset mid-PRESS_WAIT, then resume
        btn_in[0] = 1'b1;
        wait_neg(5);
        rst_n = 1'b0;
        #1;
        chk("rst_pw_level", btn_level, 4'h0);
        chk("rst_pw_press", btn_press, 4'h0);
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(10);
        chk("resume_early", btn_press, 4'h0);
        wait_neg(1);
        chk("resume_press", btn_press, 4'h1);

        // Reset mid-PRESSED: level drops at once, no release pulse
        wait_neg(3);
        saved = cnt_rel[0];
        rst_n = 1'b0;
        #1;
        chk("rst_pr_level", btn_level, 4'h0);
        chk("rst_pr_release", btn_release, 4'h0);
        btn_in = 4'h0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(20);
        chk("rst_pr_no_release", 4'(cnt_rel[0] - saved), 4'd0);
        chk("rst_pr_idle", btn_level, 4'h0);

`ifdef DEBOUNCE_REPEAT_EN
        btn_in[0] = 1'b1;
        wait_neg(11);
        chk("rep_press", btn_press, 4'h1);
        saved = cnt_rep[0];
        wait_neg(19);
        chk("rep_early", btn_repeat, 4'h0);
        wait_neg(1);
        chk("rep_first", btn_repeat, 4'h1);
        wait_neg(4);
        chk("rep_gap", btn_repeat, 4'h0);
        wait_neg(1);
        chk("rep_second", btn_repeat, 4'h1);
        wait_neg(35);
        chk("rep_count_60", 4'(cnt_rep[0] - saved), 4'd9);
        btn_in[0] = 1'b0;
        wait_neg(30);
        chk("rep_count_after_release", 4'(cnt_rep[0] - saved), 4'd11);
        chk("rep_released", btn_level, 4'h0);
`else
        btn_in[0] = 1'b1;
        wait_neg(80);
        chk("norep_level", btn_level, 4'h1);
        chk("norep_count", 4'(cnt_rep[0]), 4'd0);
        btn_in[0] = 1'b0;
        wait_neg(15);
`endif

        wait_neg(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
